// File: rtl/hazard_ctrl_unit.sv
// Stateful hazard controller for the 5-stage RV32I pipeline: EX operand forwarding,
// load-use bubbles, multi-cycle redirect flushes, data-memory freeze and a stall counter.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  is_branch,
    input  logic                  jump,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  perf_clr,
    output logic [1:0]            fwda_select,
    output logic [1:0]            fwdb_select,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  stall_all,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_USE = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [2:0]            LU_INIT   = 3'(LOAD_USE_STALLS > 1 ? LOAD_USE_STALLS - 2 : 0);
    localparam logic [2:0]            FL_INIT   = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, next_state_s, idle_next_s;
    logic [2:0]       cnt_r, cnt_next_s, idle_cnt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             redirect_s, mem_wait_s, load_use_s;
    logic             idle_lu_s, idle_flush_s, idle_stall_all_s;
    logic             lu_out_s, flush_out_s, stall_all_out_s;

    // MEM result has priority over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (mem_reg_write && (mem_rd == rs) && (rs != REG_ZERO)) begin
            return 2'b01;
        end else if (wb_reg_write && (wb_rd == rs) && (rs != REG_ZERO)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    assign fwda_select = fwd_sel(ex_rs1);
    assign fwdb_select = fwd_sel(ex_rs2);

    assign redirect_s = is_branch | jump;
    assign mem_wait_s = dmem_req & ~dmem_ready;
    assign load_use_s = ex_mem_read & (ex_rd != REG_ZERO) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Decision taken from IDLE; reused by MEM_WAIT on release and by LOAD_USE on redirect.
    always_comb begin
        idle_next_s      = IDLE;
        idle_cnt_s       = cnt_r;
        idle_lu_s        = 1'b0;
        idle_flush_s     = 1'b0;
        idle_stall_all_s = 1'b0;
        if (mem_wait_s) begin
            idle_stall_all_s = 1'b1;
            idle_next_s      = MEM_WAIT;
        end else if (redirect_s) begin
            idle_flush_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                idle_next_s = FLUSH;
                idle_cnt_s  = FL_INIT;
            end else begin
                idle_next_s = IDLE;
            end
        end else if (load_use_s) begin
            idle_lu_s = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                idle_next_s = LOAD_USE;
                idle_cnt_s  = LU_INIT;
            end else begin
                idle_next_s = IDLE;
            end
        end else begin
            idle_next_s = IDLE;
        end
    end

    // Next-state and control outputs; a memory stall inside LOAD_USE/FLUSH freezes the count.
    always_comb begin
        next_state_s    = state_r;
        cnt_next_s      = cnt_r;
        lu_out_s        = 1'b0;
        flush_out_s     = 1'b0;
        stall_all_out_s = 1'b0;
        if (rst) begin
            next_state_s = IDLE;
            cnt_next_s   = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s    = idle_next_s;
                    cnt_next_s      = idle_cnt_s;
                    lu_out_s        = idle_lu_s;
                    flush_out_s     = idle_flush_s;
                    stall_all_out_s = idle_stall_all_s;
                end
                LOAD_USE: begin
                    if (mem_wait_s) begin
                        lu_out_s        = 1'b1;
                        stall_all_out_s = 1'b1;
                    end else if (redirect_s) begin
                        next_state_s = idle_next_s;
                        cnt_next_s   = idle_cnt_s;
                        flush_out_s  = idle_flush_s;
                    end else begin
                        lu_out_s = 1'b1;
                        if (cnt_r == 3'd0) begin
                            next_state_s = IDLE;
                        end else begin
                            cnt_next_s = cnt_r - 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    flush_out_s = 1'b1;
                    if (mem_wait_s) begin
                        stall_all_out_s = 1'b1;
                    end else if (cnt_r == 3'd0) begin
                        next_state_s = IDLE;
                    end else begin
                        cnt_next_s = cnt_r - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        stall_all_out_s = 1'b1;
                    end else begin
                        next_state_s    = idle_next_s;
                        cnt_next_s      = idle_cnt_s;
                        lu_out_s        = idle_lu_s;
                        flush_out_s     = idle_flush_s;
                        stall_all_out_s = idle_stall_all_s;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    cnt_next_s   = 3'd0;
                end
            endcase
        end
    end

    // State and bubble/flush down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Saturating stall-cycle counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if ((stall_all_out_s || lu_out_s) && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_if    = lu_out_s;
    assign stall_id    = lu_out_s;
    assign bubble_ex   = lu_out_s;
    assign flush_if    = flush_out_s;
    assign flush_id    = flush_out_s;
    assign stall_all   = stall_all_out_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances with different parameters share stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
    logic       is_branch, jump, dmem_req, dmem_ready, perf_clr;

    logic [1:0]  a_fwda, a_fwdb, b_fwda, b_fwdb;
    logic        a_sif, a_sid, a_bub, a_fif, a_fid, a_sall;
    logic        b_sif, b_sid, b_bub, b_fif, b_fid, b_sall;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .FLUSH_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .is_branch(is_branch), .jump(jump), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .perf_clr(perf_clr), .fwda_select(a_fwda), .fwdb_select(a_fwdb),
        .stall_if(a_sif), .stall_id(a_sid), .bubble_ex(a_bub), .flush_if(a_fif), .flush_id(a_fid),
        .stall_all(a_sall), .stall_count(a_cnt));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .is_branch(is_branch), .jump(jump), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .perf_clr(perf_clr), .fwda_select(b_fwda), .fwdb_select(b_fwdb),
        .stall_if(b_sif), .stall_id(b_sid), .bubble_ex(b_bub), .flush_if(b_fif), .flush_id(b_fid),
        .stall_all(b_sall), .stall_count(b_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
        {is_branch, jump, dmem_req, dmem_ready, perf_clr} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd7;
        id_rs2      = 5'd7;
        id_use_rs2  = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset state, controls forced low even with a redirect present
        jump = 1'b1;
        #1;
        chk("rst_flush_if", a_fif, 1'b0);
        chk("rst_stall_all", a_sall, 1'b0);
        chk("rst_count_a", a_cnt, 16'd0);
        chk("rst_count_b", b_cnt, 4'd0);
        jump = 1'b0;
        tick();
        rst = 1'b0;

        // Forwarding
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1;
        chk("fwda_mem_beats_wb", a_fwda, 2'b01);
        chk("fwdb_x0", a_fwdb, 2'b00);
        mem_reg_write = 1'b0;
        #1;
        chk("fwda_wb", a_fwda, 2'b10);
        ex_rs2 = 5'd9; mem_rd = 5'd9; mem_reg_write = 1'b1;
        #1;
        chk("fwdb_mem", b_fwdb, 2'b01);
        chk("fwda_wb_mem_other", a_fwda, 2'b10);
        wb_reg_write = 1'b0;
        #1;
        chk("fwda_none", a_fwda, 2'b00);
        ex_rs2 = 5'd0; mem_rd = 5'd0;
        #1;
        chk("fwdb_x0_mem0", a_fwdb, 2'b00);

        // Load-use: dut_a two bubbles, dut_b one
        do_reset();
        set_load_use();
        #1;
        chk("lu_c1_stall_if", a_sif, 1'b1);
        chk("lu_c1_bubble", a_bub, 1'b1);
        chk("lu_c1_b_stall_if", b_sif, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk("lu_c2_stall_id", a_sid, 1'b1);
        chk("lu_c2_bubble", a_bub, 1'b1);
        chk("lu_c2_b_stall_if", b_sif, 1'b0);
        tick();
        chk("lu_c3_stall_if", a_sif, 1'b0);
        chk("lu_count_a", a_cnt, 16'd2);
        chk("lu_count_b", b_cnt, 4'd1);

        // Redirect: dut_a three flush cycles, load-use ignored meanwhile
        do_reset();
        jump = 1'b1;
        #1;
        chk("fl_c1_flush_if", a_fif, 1'b1);
        chk("fl_c1_stall_if", a_sif, 1'b0);
        tick();
        jump = 1'b0;
        set_load_use();
        #1;
        chk("fl_c2_flush_id", a_fid, 1'b1);
        chk("fl_c2_stall_if", a_sif, 1'b0);
        tick();
        chk("fl_c3_flush_if", a_fif, 1'b1);
        chk("fl_c3_bubble", a_bub, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("fl_c4_flush_if", a_fif, 1'b0);
        chk("fl_count_a", a_cnt, 16'd0);

        // Memory wait: four stalled cycles, release on ready
        do_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_stall_all", a_sall, 1'b1);
            chk("mw_no_flush", a_fif, 1'b0);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("mw_ready_stall_all", a_sall, 1'b0);
        tick();
        clear_inputs();
        chk("mw_count_a", a_cnt, 16'd4);
        chk("mw_count_b", b_cnt, 4'd4);

        // dut_b two-cycle flush stretched by three cycles of memory wait
        do_reset();
        jump = 1'b1;
        #1;
        chk("fm_c1_flush", b_fif, 1'b1);
        chk("fm_c1_stall_all", b_sall, 1'b0);
        tick();
        jump = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fm_wait_flush", b_fid, 1'b1);
            chk("fm_wait_stall_all", b_sall, 1'b1);
            tick();
        end
        dmem_req = 1'b0;
        #1;
        chk("fm_c5_flush", b_fif, 1'b1);
        chk("fm_c5_stall_all", b_sall, 1'b0);
        tick();
        chk("fm_c6_flush", b_fif, 1'b0);

        // Counter saturation and clear priority
        do_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count_b", b_cnt, 4'd15);
        chk("sat_count_a", a_cnt, 16'd20);
        perf_clr = 1'b1;
        tick();
        chk("clr_count_b", b_cnt, 4'd0);
        chk("clr_count_a", a_cnt, 16'd0);
        perf_clr = 1'b0;
        tick();
        chk("after_clr_count_b", b_cnt, 4'd1);

        // Reset in the middle of a flush
        do_reset();
        jump = 1'b1;
        #1;
        chk("mr_c1_flush", a_fif, 1'b1);
        tick();
        jump = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_rst_flush", a_fif, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_after_flush", a_fif, 1'b0);
        chk("mr_after_stall", a_sif, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RV32I core, replacing the purely combinational forwarding/flush logic with a stateful unit. Generates EX-stage operand forwarding selects, detects load-use hazards and inserts a configurable number of bubbles, holds multi-cycle redirect flushes, and freezes the whole pipeline while the data memory is not ready. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
- REG_ADDR_W, 5, register index width
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7)
- FLUSH_CYCLES, 1, cycles flush_if/flush_id stay high per redirect (1..7)
- CNT_W, 16, stall counter width

- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2, ex_rd  in  REG_ADDR_W  EX-stage register indices
- ex_mem_read  in  1  EX instruction is a load
- mem_rd, wb_rd  in  REG_ADDR_W  destination indices in MEM/WB
- mem_reg_write, wb_reg_write  in  1  MEM/WB instruction writes rd
- is_branch, jump  in  1  taken branch / jump resolved in EX (redirect)
- dmem_req, dmem_ready  in  1  MEM-stage data access pending / completed
- perf_clr  in  1  synchronous clear of stall_count
- fwda_select, fwdb_select  out  2  00 regfile, 01 MEM result, 10 WB result
- stall_if, stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_if, flush_id  out  1  kill IF/ID and ID/EX contents
- stall_all  out  1  freeze every pipeline register
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding (combinational, every state): A-select 01 if mem_reg_write & mem_rd==ex_rs1 & ex_rs1!=0; else 10 if wb_reg_write & wb_rd==ex_rs1 & ex_rs1!=0; else 00. B identical with ex_rs2. MEM beats WB.
- redirect = is_branch | jump. mem_wait = dmem_req & ~dmem_ready. load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- States: IDLE, LOAD_USE, FLUSH, MEM_WAIT; 3-bit down-counter cnt.
- Priority in every state: mem_wait > redirect > load_use.
- IDLE: mem_wait -> stall_all=1, go MEM_WAIT. Else redirect -> flush_if=flush_id=1; if FLUSH_CYCLES>1 go FLUSH, cnt=FLUSH_CYCLES-2. Else load_use -> stall_if=stall_id=bubble_ex=1; if LOAD_USE_STALLS>1 go LOAD_USE, cnt=LOAD_USE_STALLS-2.
- LOAD_USE: stall_if=stall_id=bubble_ex=1; cnt==0 -> IDLE, else cnt-1. redirect -> flush takes over as from IDLE (load-use dropped).
- FLUSH: flush_if=flush_id=1, load_use and redirect ignored; cnt==0 -> IDLE, else cnt-1.
- MEM_WAIT: stall_all=~dmem_ready. While dmem_ready=0: all other control outputs 0, stay. On dmem_ready=1: stall_all=0, outputs and next state evaluated exactly as IDLE in the same cycle.
- mem_wait in LOAD_USE or FLUSH: stall_all=1, state's own outputs stay asserted, cnt frozen, state held (no MEM_WAIT entry).
- stall_count: +1 each cycle stall_all|stall_if is 1; saturates at all-ones; perf_clr wins over increment (clears to 0).

## Timing
- Reset: state IDLE, cnt=0, stall_count=0; all control outputs 0 while rst high (forward selects remain combinational).
- Forwarding and first-cycle stall/flush/stall_all responses: zero latency (same cycle as inputs).
- Load-use: exactly LOAD_USE_STALLS consecutive stall cycles absent mem_wait; redirect: exactly FLUSH_CYCLES flush cycles.
- rst mid-sequence: next cycle IDLE, no residual stall/flush.

## Test plan
- ex_rs1=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 -> fwda_select=01; ex_rs2=0 with mem_rd=0 -> fwdb_select=00.
- LOAD_USE_STALLS=2: load in EX, ex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_if/stall_id/bubble_ex high 2 cycles, stall_count=2.
- FLUSH_CYCLES=3: jump pulse 1 cycle -> flush_if/flush_id high 3 cycles; load_use during cycles 2-3 ignored.
- dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> stall_all high 4 cycles, low on ready cycle, stall_count=4.
- FLUSH_CYCLES=2, mem_wait in flush cycle 2 for 3 cycles -> flush held 3 extra cycles, total flush 5 cycles, then IDLE.
- CNT_W=4: 20 stall cycles -> stall_count=15; perf_clr concurrent with stall -> 0.
